// File: rtl/vga_pattern_timing.sv
// vga_pattern_timing: parametrised VGA timing generator with run-time selectable
// test pictures, exporting pixel coordinates and a frame counter for overlays.
// Optional build macro: VGA_PATTERN_BORDER_EN adds a 1-pixel white border on the
// outermost active rows/columns; timing and latency are unchanged either way.
module vga_pattern_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int COLOR_BITS = 8
) (
  input  logic                                              clk_pixel,
  input  logic                                              reset,
  input  logic [2:0]                                        pattern_sel,
  output logic [COLOR_BITS-1:0]                             vga_r,
  output logic [COLOR_BITS-1:0]                             vga_g,
  output logic [COLOR_BITS-1:0]                             vga_b,
  output logic                                              vga_hsync,
  output logic                                              vga_vsync,
  output logic                                              vga_blank,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      pos_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      pos_y,
  output logic                                              frame_start,
  output logic [15:0]                                       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [HW-1:0] MOVE_STEP = HW'(4);
  localparam logic [HW-1:0] MOVE_SPAN = HW'(16);
  localparam logic [COLOR_BITS-1:0] C_MAX = '1;

  // Raster counters and frame bookkeeping
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [2:0]    pattern_q;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [HW-1:0] bar_left_q, bar_left_d;   // moving-bar left edge = (frame_count*4) mod H_ACTIVE
  logic          first_frame_q, first_frame_d;

  // Registered outputs
  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic                  hsync_q, vsync_q, blank_q, frame_start_q;
  logic [HW-1:0]         pos_x_q;
  logic [VW-1:0]         pos_y_q;

  logic          h_last, v_last, at_origin, active, hs_act, vs_act;
  logic [HW-1:0] bar_step, bar_off;
  logic [2:0]    bar_idx;
  logic [7:1]    bar_ge;
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;

  assign h_last    = (hcnt_q == H_LAST);
  assign v_last    = (vcnt_q == V_LAST);
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  assign active    = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
  assign hs_act    = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
  assign vs_act    = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);

  // Colour-bar boundaries; the last bar runs to the end of the active line
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign bar_ge[gi] = (hcnt_q >= HW'(gi * BAR_W));
  end

  // Next raster position: hcnt wraps each line, vcnt advances on that wrap
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
    end
  end

  // Frame counter and moving-bar position advance together at pixel (0,0),
  // except for the very first frame after reset which stays frame 0
  always_comb begin
    frame_count_d = frame_count_q;
    bar_left_d    = bar_left_q;
    first_frame_d = first_frame_q;
    bar_step      = bar_left_q + MOVE_STEP;
    if (at_origin) begin
      first_frame_d = 1'b0;
      if (!first_frame_q) begin
        frame_count_d = frame_count_q + 16'd1;
        // Restart the bar at 0 when the count wraps so it always equals count*4 mod width
        if (frame_count_d == 16'd0) bar_left_d = '0;
        else if (bar_step >= H_ACT_END) bar_left_d = bar_step - H_ACT_END;
        else bar_left_d = bar_step;
      end
    end
  end

  // Pattern colour for the current counter position (uses this frame's bar edge)
  always_comb begin
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) bar_idx = 3'(i);
    end
    bar_off = (hcnt_q >= bar_left_d) ? hcnt_q - bar_left_d
                                     : hcnt_q + H_ACT_END - bar_left_d;
    case (pattern_q)
      3'd1: begin
        // Bar order W,Y,C,G,M,R,B,K maps to r=~idx[1], g=~idx[2], b=~idx[0]
        pix_r = {COLOR_BITS{~bar_idx[1]}};
        pix_g = {COLOR_BITS{~bar_idx[2]}};
        pix_b = {COLOR_BITS{~bar_idx[0]}};
      end
      3'd2: begin
        pix_r = hcnt_q[COLOR_BITS-1:0];
        pix_g = hcnt_q[COLOR_BITS-1:0];
        pix_b = hcnt_q[COLOR_BITS-1:0];
      end
      3'd3: begin
        if (hcnt_q[5] ^ vcnt_q[5]) begin
          pix_r = C_MAX; pix_g = C_MAX; pix_b = C_MAX;
        end
      end
      3'd4: begin
        pix_b = C_MAX;
        if (bar_off < MOVE_SPAN) begin
          pix_r = C_MAX; pix_g = C_MAX;
        end
      end
      3'd5: begin
        pix_r = C_MAX; pix_g = C_MAX; pix_b = C_MAX;
      end
      default: ;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((hcnt_q == '0) || (hcnt_q == H_ACT_END - 1'b1) ||
        (vcnt_q == '0) || (vcnt_q == V_ACT_END - 1'b1)) begin
      pix_r = C_MAX; pix_g = C_MAX; pix_b = C_MAX;
    end
`endif
  end

  // State and output registers; outputs describe the counters of the previous cycle
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pattern_q     <= '0;
      frame_count_q <= '0;
      bar_left_q    <= '0;
      first_frame_q <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      blank_q       <= 1'b1;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      if (h_last && v_last) pattern_q <= pattern_sel;
      frame_count_q <= frame_count_d;
      bar_left_q    <= bar_left_d;
      first_frame_q <= first_frame_d;
      r_q           <= active ? pix_r : '0;
      g_q           <= active ? pix_g : '0;
      b_q           <= active ? pix_b : '0;
      blank_q       <= ~active;
      hsync_q       <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_q       <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      pos_x_q       <= hcnt_q;
      pos_y_q       <= vcnt_q;
      frame_start_q <= at_origin;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank   = blank_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_timing.sv
// Testbench for vga_pattern_timing: small raster, randomized pattern requests and
// reset pulses; expected outputs come from an arithmetic model of the raster
// (pixel index -> x, y, frame) queued per clock and checked by a separate monitor.
module tb_vga_pattern_timing;

  localparam int HA = 42, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VS = 3, VBP = 3;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int CB = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int MAXC = (1 << CB) - 1;
  localparam int N_CYC = 40000;

  typedef struct packed {
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
    logic          blank;
    logic          hs;
    logic          vs;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          fs;
    logic [15:0]   fc;
  } obs_t;

  logic          clk_pixel;
  logic          reset;
  logic [2:0]    pattern_sel;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic          vga_hsync, vga_vsync, vga_blank;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          frame_start;
  logic [15:0]   frame_count;

  obs_t exp_q[$];
  int   pat_by_frame[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bar_rgb[8] = '{7, 6, 3, 2, 5, 4, 1, 0};   // W,Y,C,G,M,R,B,K as {r,g,b} bits
  int   sched[12]  = '{1, 4, 3, 2, 4, 5, 0, 6, 4, 7, 1, 4};

  vga_pattern_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .COLOR_BITS(CB)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .pattern_sel(pattern_sel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .pos_x(pos_x), .pos_y(pos_y),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  function automatic obs_t reset_obs();
    obs_t o;
    o       = '0;
    o.blank = 1'b1;
    o.hs    = ~HPOL;
    o.vs    = ~VPOL;
    return o;
  endfunction

  // Expected outputs for the t-th displayed pixel since reset released
  function automatic obs_t model_pixel(int t);
    obs_t o;
    int x, y, f, pat, idx, rgb3, lft, off, r, g, b;
    bit act;
    x   = t % HT;
    y   = (t / HT) % VT;
    f   = t / FT;
    pat = pat_by_frame[f];
    act = (x < HA) && (y < VA);
    r = 0; g = 0; b = 0;
    if (act) begin
      case (pat)
        1: begin
          idx = x / (HA / 8);
          if (idx > 7) idx = 7;
          rgb3 = bar_rgb[idx];
          r = rgb3[2] ? MAXC : 0;
          g = rgb3[1] ? MAXC : 0;
          b = rgb3[0] ? MAXC : 0;
        end
        2: begin r = x % (MAXC + 1); g = r; b = r; end
        3: if (((x / 32) % 2) != ((y / 32) % 2)) begin r = MAXC; g = MAXC; b = MAXC; end
        4: begin
          lft = ((f % 65536) * 4) % HA;
          off = (x - lft + HA) % HA;
          b = MAXC;
          if (off < 16) begin r = MAXC; g = MAXC; end
        end
        5: begin r = MAXC; g = MAXC; b = MAXC; end
        default: ;
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) begin
        r = MAXC; g = MAXC; b = MAXC;
      end
`endif
    end
    o.r     = CB'(r);
    o.g     = CB'(g);
    o.b     = CB'(b);
    o.blank = !act;
    o.hs    = (x >= HA + HFP && x < HA + HFP + HS) ? HPOL : ~HPOL;
    o.vs    = (y >= VA + VFP && y < VA + VFP + VS) ? VPOL : ~VPOL;
    o.px    = XW'(x);
    o.py    = YW'(y);
    o.fs    = (x == 0 && y == 0);
    o.fc    = 16'(f % 65536);
    return o;
  endfunction

  // Monitor: one expected entry per clock, checked 1 time unit after the edge
  initial begin
    obs_t e;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_underflow: DUT output with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({vga_r, vga_g, vga_b, vga_blank} !== {e.r, e.g, e.b, e.blank}) begin
          n_fail++;
          $display("FAIL pixel @%0t x=%0d y=%0d: got rgb=%h/%h/%h blank=%b, want rgb=%h/%h/%h blank=%b",
                   $time, e.px, e.py, vga_r, vga_g, vga_b, vga_blank, e.r, e.g, e.b, e.blank);
        end
        n_checks++;
        if ({vga_hsync, vga_vsync, pos_x, pos_y, frame_start, frame_count} !==
            {e.hs, e.vs, e.px, e.py, e.fs, e.fc}) begin
          n_fail++;
          $display("FAIL timing @%0t: got hs=%b vs=%b x=%0d y=%0d fs=%b fc=%0d, want hs=%b vs=%b x=%0d y=%0d fs=%b fc=%0d",
                   $time, vga_hsync, vga_vsync, pos_x, pos_y, frame_start, frame_count,
                   e.hs, e.vs, e.px, e.py, e.fs, e.fc);
        end
      end
    end
  end

  // Stimulus: drive inputs for the next edge and queue the response it should produce
  initial begin
    int  k;
    bit  rst_now;
    k           = 0;
    reset       = 1'b1;
    pattern_sel = 3'd0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      rst_now = (cyc < 4) || (cyc == 5000) || (cyc >= 7000 && cyc < 7003);
      reset   = rst_now;
      if (!rst_now) begin
        // Deterministic request just before each frame boundary, random noise elsewhere
        if ((k % FT) >= FT - 100) pattern_sel = 3'(sched[(k / FT) % 12]);
        else if (cyc % 257 == 0) pattern_sel = 3'($urandom_range(0, 7));
      end else if (cyc % 2 == 0) begin
        pattern_sel = 3'($urandom_range(0, 7));
      end
      if (rst_now) begin
        exp_q.push_back(reset_obs());
        k = 0;
        pat_by_frame.delete();
        pat_by_frame.push_back(0);
      end else begin
        exp_q.push_back(model_pixel(k));
        if (k % FT == FT - 1) pat_by_frame.push_back(int'(pattern_sel));
        k++;
      end
      @(negedge clk_pixel);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
